rgb_mosaic: RTL
===============

Name: rgb_mosaic

Overview:
- Converts a per-pixel RGB stream (r/g/b plus dtype/meta) back into a single-channel Bayer stream on the standard dvi/dtype/data interface.
- Selects one colour per pixel according to a programmable 2-bit Bayer phase.
- Sits upstream of Bayer-domain blocks; used to re-mosaic processed or synthetic RGB for test patterns, and for loopback against the bilinear demosaic.
- Also measures frame geometry and flags ragged rows.

Parameters:
- PIXEL_WIDTH, 10, bits per colour channel and per output Bayer pixel.
- DATA_WIDTH, 16, width of datao and meta_datai.
- NUM_COLS_WIDTH, 11, width of column counter and num_cols.
- NUM_ROWS_WIDTH, 11, width of row counter and num_rows.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- dvi  input  1  input data valid.
- dtypei  input  `DTYPE_WIDTH  input data type.
- r  input  PIXEL_WIDTH  red channel.
- g  input  PIXEL_WIDTH  green channel.
- b  input  PIXEL_WIDTH  blue channel.
- meta_datai  input  DATA_WIDTH  payload for non-pixel dtypes.
- phase  input  2  Bayer phase; [1]=row phase, [0]=col phase.
- dvo  output  1  output valid.
- dtypeo  output  `DTYPE_WIDTH  output data type (dtypei delayed).
- datao  output  DATA_WIDTH  Bayer pixel (zero-extended) or meta passthrough.
- num_cols  output  NUM_COLS_WIDTH  pixels in first row of last completed frame.
- num_rows  output  NUM_ROWS_WIDTH  rows in last completed frame.
- row_len_err  output  1  some row in last completed frame differed in length from its first row.

Behaviour:
- Reset: while reset=1 at a clk edge, every output and every internal register clears to 0. Reset wins over any simultaneous input. A frame interrupted by reset produces no num_cols/num_rows update.
- Latency: exactly 1 cycle. dvo and dtypeo equal dvi and dtypei of the previous cycle. When dvi=0, datao holds its last value.
- Phase tracking, on dvi=1 only:
  - FRAME_START: row_phase <= phase[1]; row_cnt <= 0; frame_err <= 0; first_row <= 1.
  - ROW_START: col_phase <= phase[0]; col_cnt <= 0.
  - Pixel (dtypei & `DTYPE_PIXEL_MASK nonzero): col_phase toggles; col_cnt increments, saturating at all-ones.
  - ROW_END: row_phase toggles; row_cnt increments, saturating. If first_row: row_len <= col_cnt and first_row <= 0. Otherwise, if col_cnt != row_len, frame_err <= 1.
  - FRAME_END: num_cols <= row_len; num_rows <= row_cnt; row_len_err <= frame_err. All three update in the same cycle as dvo for that FRAME_END.
  - phase changes take effect only at the next FRAME_START / ROW_START.
- Pixel select, using {row_phase, col_phase} before the toggle:
  - 0 -> r
  - 1 -> g
  - 2 -> g
  - 3 -> b
  - datao <= {zeros, selected}.
- Non-pixel dtypes with dvi=1: datao <= meta_datai.
- Unknown dtypes: passed through like meta; no state change.
- Missing ROW_END before the next ROW_START: col_cnt restarts; row_cnt is not incremented.
- FRAME_END with zero rows: num_rows=0, num_cols=0, row_len_err=0.

Test Plan:
- Reset mid-frame: assert reset for 1 cycle during a pixel -> next cycle dvo=0, datao=0, num_rows=0. A following frame measures correctly.
- phase=0, 4x2 frame, r=0x3FF, g=0x155, b=0x0AA -> row0 datao 0x3FF,0x155,0x3FF,0x155; row1 0x155,0x0AA,0x155,0x0AA. Each value appears 1 cycle after its input.
- phase=3, same frame -> row0 0x0AA,0x155,0x0AA,0x155; row1 0x155,0x3FF,0x155,0x3FF.
- Gapped dvi (valid every 3rd cycle) with meta_datai=0xBEEF on FRAME_START -> datao=0xBEEF with dtypeo=FRAME_START. Pixel sequence is identical to the gapless case.
- 6-col x 5-row frame -> at FRAME_END: num_cols=6, num_rows=5, row_len_err=0. A repeat frame with row 3 of 5 pixels -> row_len_err=1. The next clean frame -> row_len_err=0.
- Loopback: rgb_mosaic output into interp_bilinear with matching phase, flat field r=g=b=0x200 -> all demosaiced outputs equal 0x200.

Source files
------------

// File: rtl/rgb_mosaic.sv
// Re-mosaics a per-pixel RGB stream into a single-channel Bayer stream, one cycle of latency,
// while measuring frame geometry (first-row width, row count) and flagging ragged rows.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'h3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'h4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'h8
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 4'h8
`endif

module rgb_mosaic #(
   parameter int PIXEL_WIDTH    = 10,
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_COLS_WIDTH = 11,
   parameter int NUM_ROWS_WIDTH = 11
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      dvi,
   input  logic [`DTYPE_WIDTH-1:0]   dtypei,
   input  logic [PIXEL_WIDTH-1:0]    r,
   input  logic [PIXEL_WIDTH-1:0]    g,
   input  logic [PIXEL_WIDTH-1:0]    b,
   input  logic [DATA_WIDTH-1:0]     meta_datai,
   input  logic [1:0]                phase,
   output logic                      dvo,
   output logic [`DTYPE_WIDTH-1:0]   dtypeo,
   output logic [DATA_WIDTH-1:0]     datao,
   output logic [NUM_COLS_WIDTH-1:0] num_cols,
   output logic [NUM_ROWS_WIDTH-1:0] num_rows,
   output logic                      row_len_err
);

   logic                      row_phase_q, row_phase_d;
   logic                      col_phase_q, col_phase_d;
   logic [NUM_COLS_WIDTH-1:0] col_cnt_q, col_cnt_d;
   logic [NUM_ROWS_WIDTH-1:0] row_cnt_q, row_cnt_d;
   logic [NUM_COLS_WIDTH-1:0] row_len_q, row_len_d;
   logic                      first_row_q, first_row_d;
   logic                      frame_err_q, frame_err_d;
   logic                      dvo_q, dvo_d;
   logic [`DTYPE_WIDTH-1:0]   dtypeo_q, dtypeo_d;
   logic [DATA_WIDTH-1:0]     datao_q, datao_d;
   logic [NUM_COLS_WIDTH-1:0] num_cols_q, num_cols_d;
   logic [NUM_ROWS_WIDTH-1:0] num_rows_q, num_rows_d;
   logic                      row_len_err_q, row_len_err_d;
   logic [PIXEL_WIDTH-1:0]    pix_sel_s;
   logic                      is_pix_s;

   // Bayer colour pick from the current (pre-toggle) row/col phase.
   always_comb begin
      pix_sel_s = r;
      case ({row_phase_q, col_phase_q})
         2'd0:    pix_sel_s = r;
         2'd1:    pix_sel_s = g;
         2'd2:    pix_sel_s = g;
         2'd3:    pix_sel_s = b;
         default: pix_sel_s = r;
      endcase
   end

   assign is_pix_s = ((dtypei & `DTYPE_PIXEL_MASK) != {`DTYPE_WIDTH{1'b0}});

   // Next-state for phase tracking, geometry measurement and the output stage.
   always_comb begin
      row_phase_d   = row_phase_q;
      col_phase_d   = col_phase_q;
      col_cnt_d     = col_cnt_q;
      row_cnt_d     = row_cnt_q;
      row_len_d     = row_len_q;
      first_row_d   = first_row_q;
      frame_err_d   = frame_err_q;
      datao_d       = datao_q;
      num_cols_d    = num_cols_q;
      num_rows_d    = num_rows_q;
      row_len_err_d = row_len_err_q;
      dvo_d         = dvi;
      dtypeo_d      = dtypei;
      if (dvi) begin
         if (is_pix_s) begin
            datao_d     = DATA_WIDTH'(pix_sel_s);
            col_phase_d = ~col_phase_q;
            if (col_cnt_q != {NUM_COLS_WIDTH{1'b1}}) begin
               col_cnt_d = col_cnt_q + {{(NUM_COLS_WIDTH-1){1'b0}}, 1'b1};
            end else begin
               col_cnt_d = col_cnt_q;
            end
         end else begin
            datao_d = meta_datai;
            case (dtypei)
               `DTYPE_FRAME_START: begin
                  row_phase_d = phase[1];
                  row_cnt_d   = {NUM_ROWS_WIDTH{1'b0}};
                  row_len_d   = {NUM_COLS_WIDTH{1'b0}};
                  frame_err_d = 1'b0;
                  first_row_d = 1'b1;
               end
               `DTYPE_ROW_START: begin
                  col_phase_d = phase[0];
                  col_cnt_d   = {NUM_COLS_WIDTH{1'b0}};
               end
               `DTYPE_ROW_END: begin
                  row_phase_d = ~row_phase_q;
                  if (row_cnt_q != {NUM_ROWS_WIDTH{1'b1}}) begin
                     row_cnt_d = row_cnt_q + {{(NUM_ROWS_WIDTH-1){1'b0}}, 1'b1};
                  end else begin
                     row_cnt_d = row_cnt_q;
                  end
                  if (first_row_q) begin
                     row_len_d   = col_cnt_q;
                     first_row_d = 1'b0;
                  end else if (col_cnt_q != row_len_q) begin
                     frame_err_d = 1'b1;
                  end else begin
                     frame_err_d = frame_err_q;
                  end
               end
               `DTYPE_FRAME_END: begin
                  num_cols_d    = row_len_q;
                  num_rows_d    = row_cnt_q;
                  row_len_err_d = frame_err_q;
               end
               default: begin
                  row_phase_d = row_phase_q;
               end
            endcase
         end
      end else begin
         datao_d = datao_q;
      end
   end

   // State and registered outputs; reset overrides any concurrent input.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_phase_q   <= 1'b0;
         col_phase_q   <= 1'b0;
         col_cnt_q     <= {NUM_COLS_WIDTH{1'b0}};
         row_cnt_q     <= {NUM_ROWS_WIDTH{1'b0}};
         row_len_q     <= {NUM_COLS_WIDTH{1'b0}};
         first_row_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         dvo_q         <= 1'b0;
         dtypeo_q      <= {`DTYPE_WIDTH{1'b0}};
         datao_q       <= {DATA_WIDTH{1'b0}};
         num_cols_q    <= {NUM_COLS_WIDTH{1'b0}};
         num_rows_q    <= {NUM_ROWS_WIDTH{1'b0}};
         row_len_err_q <= 1'b0;
      end else begin
         row_phase_q   <= row_phase_d;
         col_phase_q   <= col_phase_d;
         col_cnt_q     <= col_cnt_d;
         row_cnt_q     <= row_cnt_d;
         row_len_q     <= row_len_d;
         first_row_q   <= first_row_d;
         frame_err_q   <= frame_err_d;
         dvo_q         <= dvo_d;
         dtypeo_q      <= dtypeo_d;
         datao_q       <= datao_d;
         num_cols_q    <= num_cols_d;
         num_rows_q    <= num_rows_d;
         row_len_err_q <= row_len_err_d;
      end
   end

   assign dvo         = dvo_q;
   assign dtypeo      = dtypeo_q;
   assign datao       = datao_q;
   assign num_cols    = num_cols_q;
   assign num_rows    = num_rows_q;
   assign row_len_err = row_len_err_q;

endmodule
